tsp_2opt_sched: RTL and testbench

- Sequencing controller for the tsp tour-improvement datapath: runs 2-opt sweeps over the current tour held in path.
- Enumerates every legal edge pair (i,j) and streams them to the delta-evaluation unit over a valid/ready handshake.
- Collects the returned cost deltas in order and keeps the best improving move of each sweep.
- At sweep end, commands the path memory to reverse path[i+1..j]; repeats until no improvement is found or the sweep limit is reached.

---
 rtl/tsp_pkg.sv | 28 ++
 rtl/tsp_pair_iter.sv | 67 ++++++
 rtl/tsp_2opt_sched.sv | 193 +++++++++++++++++++
 tb/tb_tsp_2opt_sched.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/tsp_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : tsp_pkg
//  Purpose  : Shared constants, index/delta types and the sweep controller
//             state encoding for the tsp 2-opt tour-improvement block.
//  Revision : 1.0  initial release
// ============================================================================
package tsp_pkg;

  localparam int N_CITY    = 64;
  localparam int IDX_W     = 6;
  localparam int DELTA_W   = 32;
  localparam int MAX_OUT   = 4;
  localparam int MAX_SWEEP = 100;

  typedef logic [IDX_W-1:0]          city_idx_t;
  typedef logic signed [DELTA_W-1:0] delta_t;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    DRAIN = 3'd2,
    APPLY = 3'd3,
    FIN   = 3'd4
  } state_t;

endpackage
`default_nettype wire

// File: rtl/tsp_pair_iter.sv
`default_nettype none
// ============================================================================
//  Module   : tsp_pair_iter
//  Purpose  : Walks the legal 2-opt edge pairs (i, j) in sweep order:
//             i = 0..N-3, j = i+2..N-1, with (0, N-1) skipped. Holds on the
//             last pair instead of wrapping.
//  Revision : 1.0  initial release
// ============================================================================
module tsp_pair_iter
  import tsp_pkg::*;
#(
  parameter int N_CITY = tsp_pkg::N_CITY,
  parameter int IDX_W  = tsp_pkg::IDX_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             step_i,
  output logic [IDX_W-1:0] i_o,
  output logic [IDX_W-1:0] j_o,
  output logic             last_o
);

  localparam logic [IDX_W-1:0] c_i_last    = IDX_W'(N_CITY - 3);
  localparam logic [IDX_W-1:0] c_j_last    = IDX_W'(N_CITY - 1);
  localparam logic [IDX_W-1:0] c_j_row0    = IDX_W'(N_CITY - 2);
  localparam logic [IDX_W-1:0] c_j_first   = IDX_W'(2);

  logic [IDX_W-1:0] i_q, i_d, j_q, j_d;
  logic             w_row_end;

  // Row 0 ends one early because edge pair (0, N-1) shares a city.
  assign w_row_end = (j_q == ((i_q == '0) ? c_j_row0 : c_j_last));
  assign last_o    = (i_q == c_i_last) && (j_q == c_j_last);
  assign i_o       = i_q;
  assign j_o       = j_q;

  // Next pair: advance j, or move to the next row starting at i+2.
  always_comb begin
    i_d = i_q;
    j_d = j_q;
    if (clr_i) begin
      i_d = '0;
      j_d = c_j_first;
    end else if (step_i && !last_o) begin
      if (w_row_end) begin
        i_d = i_q + IDX_W'(1);
        j_d = i_q + IDX_W'(3);
      end else begin
        j_d = j_q + IDX_W'(1);
      end
    end
  end

  // Pair registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      i_q <= '0;
      j_q <= c_j_first;
    end else begin
      i_q <= i_d;
      j_q <= j_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/tsp_2opt_sched.sv
`default_nettype none
// ============================================================================
//  Module   : tsp_2opt_sched
//  Purpose  : 2-opt sweep sequencer. Streams every legal edge pair to the
//             delta evaluator, tracks the best improving move per sweep and
//             commands the path reversal, repeating until no gain or the
//             sweep limit.
//  Revision : 1.0  initial release
// ============================================================================
module tsp_2opt_sched
  import tsp_pkg::*;
#(
  parameter int N_CITY    = tsp_pkg::N_CITY,
  parameter int IDX_W     = tsp_pkg::IDX_W,
  parameter int DELTA_W   = tsp_pkg::DELTA_W,
  parameter int MAX_OUT   = tsp_pkg::MAX_OUT,
  parameter int MAX_SWEEP = tsp_pkg::MAX_SWEEP
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  output logic                      busy,
  output logic                      done,
  output logic                      eval_valid,
  input  logic                      eval_ready,
  output logic [IDX_W-1:0]          eval_i,
  output logic [IDX_W-1:0]          eval_j,
  input  logic                      res_valid,
  input  logic signed [DELTA_W-1:0] res_delta,
  output logic                      rev_valid,
  input  logic                      rev_ready,
  output logic [IDX_W-1:0]          rev_i,
  output logic [IDX_W-1:0]          rev_j,
  output logic [7:0]                sweep_cnt,
  output logic signed [DELTA_W-1:0] best_delta,
  output logic                      err
);

  localparam int               OUT_W     = $clog2(MAX_OUT + 1);
  localparam logic [OUT_W-1:0] c_max_out = OUT_W'(MAX_OUT);

  state_t                      state_q, state_d;
  logic [OUT_W-1:0]            out_q, out_d;
  logic                        res_done_q, res_done_d;
  logic signed [DELTA_W-1:0]   best_q, best_d;
  logic [IDX_W-1:0]            bi_q, bi_d, bj_q, bj_d;
  logic signed [DELTA_W-1:0]   bdelta_q, bdelta_d;
  logic [7:0]                  sweep_q, sweep_d;
  logic                        done_q, done_d;
  logic                        err_q, err_d;

  logic                        w_clr, w_xfer, w_res_ok;
  logic [IDX_W-1:0]            w_iss_i, w_iss_j, w_res_i, w_res_j;
  logic                        w_iss_last, w_res_last;

  // Issue side: the pair currently offered to the evaluator.
  tsp_pair_iter #(.N_CITY(N_CITY), .IDX_W(IDX_W)) u_iss_iter (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (w_clr),
    .step_i (w_xfer),
    .i_o    (w_iss_i),
    .j_o    (w_iss_j),
    .last_o (w_iss_last)
  );

  // Result side: results come back in order, so this tracks their owner.
  tsp_pair_iter #(.N_CITY(N_CITY), .IDX_W(IDX_W)) u_res_iter (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (w_clr),
    .step_i (w_res_ok),
    .i_o    (w_res_i),
    .j_o    (w_res_j),
    .last_o (w_res_last)
  );

  assign eval_valid = (state_q == ISSUE) && (out_q < c_max_out);
  assign w_xfer     = eval_valid && eval_ready;
  assign w_res_ok   = res_valid && (out_q != '0);
  assign eval_i     = eval_valid ? w_iss_i : '0;
  assign eval_j     = eval_valid ? w_iss_j : '0;
  assign rev_valid  = (state_q == APPLY);
  assign rev_i      = bi_q;
  assign rev_j      = bj_q;
  assign busy       = (state_q == ISSUE) || (state_q == DRAIN) || (state_q == APPLY);
  assign done       = done_q;
  assign err        = err_q;
  assign sweep_cnt  = sweep_q;
  assign best_delta = bdelta_q;

  // Next-state logic: result bookkeeping first, then the sweep FSM, so a
  // start or sweep restart overrides anything the result path wrote.
  always_comb begin
    state_d    = state_q;
    out_d      = out_q + OUT_W'(w_xfer) - OUT_W'(w_res_ok);
    res_done_d = res_done_q;
    best_d     = best_q;
    bi_d       = bi_q;
    bj_d       = bj_q;
    bdelta_d   = bdelta_q;
    sweep_d    = sweep_q;
    done_d     = done_q;
    err_d      = err_q;
    w_clr      = 1'b0;

    if (res_valid && (out_q == '0)) begin
      err_d = 1'b1;
    end
    if (w_res_ok) begin
      if (w_res_last) begin
        res_done_d = 1'b1;
      end
      if (res_delta < best_q) begin
        best_d = res_delta;
        bi_d   = w_res_i;
        bj_d   = w_res_j;
      end
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d    = ISSUE;
          sweep_d    = '0;
          done_d     = 1'b0;
          err_d      = 1'b0;
          w_clr      = 1'b1;
          best_d     = '0;
          res_done_d = 1'b0;
        end
      end
      ISSUE: begin
        if (w_xfer && w_iss_last) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if ((out_q == '0) && res_done_q) begin
          bdelta_d = best_q;
          state_d  = (best_q < 0) ? APPLY : FIN;
        end
      end
      APPLY: begin
        if (rev_ready) begin
          sweep_d = sweep_q + 8'd1;
          if ((int'(sweep_q) + 1) >= MAX_SWEEP) begin
            state_d = FIN;
          end else begin
            state_d    = ISSUE;
            w_clr      = 1'b1;
            best_d     = '0;
            res_done_d = 1'b0;
          end
        end
      end
      FIN: begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      out_q      <= '0;
      res_done_q <= 1'b0;
      best_q     <= '0;
      bi_q       <= '0;
      bj_q       <= '0;
      bdelta_q   <= '0;
      sweep_q    <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      out_q      <= out_d;
      res_done_q <= res_done_d;
      best_q     <= best_d;
      bi_q       <= bi_d;
      bj_q       <= bj_d;
      bdelta_q   <= bdelta_d;
      sweep_q    <= sweep_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_tsp_2opt_sched.sv
`default_nettype none
// ============================================================================
//  Module   : tb_tsp_2opt_sched
//  Purpose  : Self-checking bench for tsp_2opt_sched at N_CITY=8, MAX_SWEEP=3
//             with a modelled evaluation unit and path memory.
//  Revision : 1.0  initial release
// ============================================================================
module tb_tsp_2opt_sched;

  localparam int NC = 8;
  localparam int IW = 6;
  localparam int DW = 32;
  localparam int MO = 4;
  localparam int MS = 3;
  localparam int NP = NC * (NC - 3) / 2;

  logic clk = 1'b0;
  logic rst, start, eval_ready, res_valid, rev_ready;
  logic signed [DW-1:0] res_delta;
  logic busy, done, eval_valid, rev_valid, err;
  logic [IW-1:0] eval_i, eval_j, rev_i, rev_j;
  logic [7:0] sweep_cnt;
  logic signed [DW-1:0] best_delta;

  always #5 clk = ~clk;

  tsp_2opt_sched #(
    .N_CITY(NC), .IDX_W(IW), .DELTA_W(DW), .MAX_OUT(MO), .MAX_SWEEP(MS)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .eval_valid(eval_valid), .eval_ready(eval_ready),
    .eval_i(eval_i), .eval_j(eval_j),
    .res_valid(res_valid), .res_delta(res_delta),
    .rev_valid(rev_valid), .rev_ready(rev_ready),
    .rev_i(rev_i), .rev_j(rev_j),
    .sweep_cnt(sweep_cnt), .best_delta(best_delta), .err(err)
  );

  typedef struct { int due; int d; } res_t;
  typedef struct { int i; int j; int b; } rev_t;

  int   checks = 0;
  int   errors = 0;
  res_t q[$];
  rev_t revs[$];
  rev_t exp_revs[$];
  int   pi_tab[NP];
  int   pj_tab[NP];
  int   dtab[NC][NC];
  int   mode, lat, rand_rdy, hold, msweep, cyc, xidx, outst, rev_wait;
  bit   inject, p_ev, p_rv;
  int   p_ei, p_ej, p_ri, p_rj;

  task automatic chk(input string tag, input logic signed [63:0] obs,
                     input logic signed [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Cost delta the evaluator reports for pair (i,j) during sweep s.
  function automatic int dval(int m, int s, int i, int j);
    case (m)
      0: return 5;
      1: return (s == 0 && i == 1 && j == 4) ? -3 : 0;
      2: return (s == 0 && ((i == 2 && j == 5) || (i == 3 && j == 6))) ? -7 : 0;
      3: return (s == 0) ? dtab[i][j] : 0;
      4: return -1;
      default: return 0;
    endcase
  endfunction

  // One clock of the evaluator / path-memory model, acting at the negedge.
  task automatic tick();
    int pre;
    @(negedge clk);
    cyc++;
    if (p_ev) begin
      chk("eval_hold_valid", eval_valid, 1);
      chk("eval_hold_i", eval_i, p_ei);
      chk("eval_hold_j", eval_j, p_ej);
    end
    if (p_rv) begin
      chk("rev_hold_valid", rev_valid, 1);
      chk("rev_hold_i", rev_i, p_ri);
      chk("rev_hold_j", rev_j, p_rj);
    end
    chk("eval_rev_exclusive", eval_valid & rev_valid, 0);
    pre = outst;
    if (q.size() > 0 && q[0].due <= cyc) begin
      res_valid = 1'b1;
      res_delta = q[0].d;
      void'(q.pop_front());
      outst--;
    end else if (inject && q.size() == 0) begin
      res_valid = 1'b1;
      res_delta = -100;
      inject    = 1'b0;
    end else begin
      res_valid = 1'b0;
      res_delta = $urandom;
    end
    eval_ready = (rand_rdy != 0) ? 1'($urandom_range(0, 1)) : 1'b1;
    if (eval_valid && eval_ready) begin
      chk("outstanding_limit", pre < MO, 1);
      chk("pair_i", eval_i, pi_tab[xidx % NP]);
      chk("pair_j", eval_j, pj_tab[xidx % NP]);
      q.push_back('{due: cyc + lat,
                    d: dval(mode, msweep, pi_tab[xidx % NP], pj_tab[xidx % NP])});
      xidx++;
      outst++;
    end
    if (rev_valid) begin
      if (hold != 0 && rev_wait < 10) begin
        rev_ready = 1'b0;
        rev_wait++;
      end else begin
        rev_ready = 1'b1;
      end
    end else begin
      rev_ready = 1'b0;
      rev_wait  = 0;
    end
    if (rev_valid && rev_ready) begin
      revs.push_back('{i: int'(rev_i), j: int'(rev_j), b: int'(best_delta)});
      msweep++;
    end
    p_ev = eval_valid && !eval_ready;
    p_ei = int'(eval_i);
    p_ej = int'(eval_j);
    p_rv = rev_valid && !rev_ready;
    p_ri = int'(rev_i);
    p_rj = int'(rev_j);
  endtask

  task automatic chk_zero();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_eval_valid", eval_valid, 0);
    chk("rst_eval_i", eval_i, 0);
    chk("rst_eval_j", eval_j, 0);
    chk("rst_rev_valid", rev_valid, 0);
    chk("rst_rev_i", rev_i, 0);
    chk("rst_rev_j", rev_j, 0);
    chk("rst_sweep_cnt", sweep_cnt, 0);
    chk("rst_best_delta", best_delta, 0);
    chk("rst_err", err, 0);
  endtask

  // Full run: predicts every sweep from the delta rules, then drives the DUT.
  task automatic run(input int m, input int l, input int rr, input int h);
    int s, cnt, best, bi, bj, sweeps, lastbest, d, n;
    mode = m; lat = l; rand_rdy = rr; hold = h;
    msweep = 0; xidx = 0;
    revs.delete();
    exp_revs.delete();
    cnt = 0; sweeps = 0; lastbest = 0; s = 0;
    do begin
      best = 0; bi = 0; bj = 0;
      for (int k = 0; k < NP; k++) begin
        d = dval(m, s, pi_tab[k], pj_tab[k]);
        if (d < best) begin
          best = d; bi = pi_tab[k]; bj = pj_tab[k];
        end
      end
      sweeps++;
      lastbest = best;
      if (best < 0) begin
        exp_revs.push_back('{i: bi, j: bj, b: best});
        cnt++;
      end
      s++;
    end while (best < 0 && cnt < MS);

    start = 1'b1;
    tick();
    start = 1'b0;
    chk("busy_after_start", busy, 1);
    chk("done_cleared", done, 0);
    if (m == 1) begin
      repeat (5) tick();
      start = 1'b1;
      tick();
      start = 1'b0;
    end
    n = 0;
    while (!done && n < 5000) begin
      tick();
      n++;
    end
    chk("done_timeout", done, 1);
    chk("busy_at_done", busy, 0);
    chk("sweep_cnt", sweep_cnt, cnt);
    chk("best_delta", best_delta, lastbest);
    chk("err_clean", err, 0);
    chk("rev_count", revs.size(), exp_revs.size());
    for (int k = 0; k < exp_revs.size() && k < revs.size(); k++) begin
      chk("rev_i", revs[k].i, exp_revs[k].i);
      chk("rev_j", revs[k].j, exp_revs[k].j);
      chk("rev_best", revs[k].b, exp_revs[k].b);
    end
    chk("transfers", xidx, sweeps * NP);
  endtask

  initial begin
    int n, k;
    rst = 1'b0; start = 1'b0; eval_ready = 1'b0; res_valid = 1'b0;
    res_delta = '0; rev_ready = 1'b0;
    mode = 0; lat = 1; rand_rdy = 0; hold = 0; msweep = 0; cyc = 0;
    xidx = 0; outst = 0; rev_wait = 0; inject = 1'b0; p_ev = 1'b0; p_rv = 1'b0;
    p_ei = 0; p_ej = 0; p_ri = 0; p_rj = 0;

    k = 0;
    for (int i = 0; i <= NC - 3; i++) begin
      for (int j = i + 2; j <= NC - 1; j++) begin
        if (!(i == 0 && j == NC - 1)) begin
          pi_tab[k] = i;
          pj_tab[k] = j;
          k++;
        end
      end
    end

    repeat (2) @(negedge clk);
    chk_zero();
    rst = 1'b1;
    tick();

    run(0, 1, 0, 0);
    run(1, 1, 0, 0);
    run(2, 1, 0, 0);

    for (int i = 0; i < NC; i++) begin
      for (int j = 0; j < NC; j++) begin
        dtab[i][j] = int'($urandom_range(0, 60)) - 30;
      end
    end
    k = int'($urandom_range(0, NP - 1));
    dtab[pi_tab[k]][pj_tab[k]] = -40;
    run(3, 6, 1, 0);

    run(4, 2, 1, 1);

    // Reset in the middle of an issue phase with two requests in flight.
    mode = 5; lat = 6; rand_rdy = 0; hold = 0; xidx = 0; msweep = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    while (xidx < 2 && n < 100) begin
      tick();
      n++;
    end
    @(posedge clk);
    chk("mid_outstanding", outst, 2);
    #2 rst = 1'b0;
    #1 chk_zero();
    q.delete();
    outst = 0; res_valid = 1'b0; eval_ready = 1'b0; rev_ready = 1'b0;
    p_ev = 1'b0; p_rv = 1'b0; rev_wait = 0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    tick();

    run(0, 1, 0, 0);

    inject = 1'b1;
    repeat (4) tick();
    chk("stray_err", err, 1);
    chk("stray_done_kept", done, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
